// File: rtl/nbcac_encoder_seq.sv
// nbcac_encoder_seq: sequential NBCAC encoder resolving BPC greedy weight-cascade stages per clock.
module nbcac_encoder_seq #(
  parameter int DATA_W = 22,
  parameter int CODE_W = 31,
  parameter int BPC    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_err
);
  localparam int W  = DATA_W + 2;
  localparam int SW = $clog2(CODE_W + 1);
  localparam int DW = $clog2(CODE_W - 1);
  typedef logic [CODE_W:0][W-1:0] wt_t;
  function automatic wt_t calc_wt();
    wt_t w;
    w = '0;
    w[SW'(CODE_W)] = W'(2);
    w[SW'(CODE_W-1)] = W'(2);
    for (int k = CODE_W - 2; k >= 2; k--) w[SW'(k)] = w[SW'(k+1)] + w[SW'(k+2)];
    w[SW'(1)] = W'(1);
    return w;
  endfunction
  localparam wt_t WT = calc_wt();
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] r, r_n;
  logic [CODE_W-2:0] d, d_n;
  logic [SW-1:0] k;
  logic [W:0] sum;
  logic dk, last;
  int kk;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign last      = int'(k) + BPC >= CODE_W;
  always_comb begin
    state_n = state == IDLE ? (in_valid ? RUN : IDLE)
            : state == RUN  ? (last ? DONE : RUN)
            : (out_ready ? IDLE : DONE);
  end
  // Stages of one clock chain combinationally; a short final call skips stages past CODE_W-1.
  always_comb begin
    r_n = r;
    d_n = d;
    sum = '0;
    dk  = 1'b0;
    kk  = 0;
    for (int j = 0; j < BPC; j++) begin
      kk = int'(k) + j;
      if (kk <= CODE_W - 1) begin
        sum = {1'b0, WT[SW'(kk)]} + {1'b0, WT[SW'(kk+1)]};
        dk  = {1'b0, r_n} >= sum ? 1'b1 : r_n < WT[SW'(kk)] ? 1'b0 : d_n[DW'(kk-2)];
        d_n[DW'(kk-1)] = dk;
        r_n = r_n - (dk ? WT[SW'(kk)] : '0);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r        <= '0;
      d        <= '0;
      k        <= '0;
      out_code <= '0;
      out_err  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      r <= {2'b00, in_data[DATA_W-1:1], 1'b0};
      d <= (CODE_W-1)'(in_data[0]);
      k <= SW'(2);
    end else if (state == RUN) begin
      r <= r_n;
      d <= d_n;
      k <= k + SW'(BPC);
      if (last) begin
        out_code <= {r_n != '0, d_n};
        out_err  <= r_n != '0 && r_n != WT[SW'(CODE_W)];
      end
    end
  end
endmodule

// File: tb/tb_nbcac_encoder_seq.sv
// tb_nbcac_encoder_seq: directed and random checks of several encoder configurations against a greedy-cascade model.
module tb_nbcac_encoder_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv[5], ir[5], ov[5], ory[5], oe[5];
  logic [21:0] id[5];
  logic [30:0] oc0, oc1, oc2;
  logic [4:0] oc3;
  logic [3:0] oc4;
  int cwv[5] = '{31, 31, 31, 5, 4};
  int bpv[5] = '{1, 3, 29, 2, 1};
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc[5];
  int chk_acc[5] = '{-1, -1, -1, -1, -1};
  logic [31:0] q[5][$];
  logic [31:0] got;

  always #5 clk = ~clk;

  nbcac_encoder_seq #(.DATA_W(22), .CODE_W(31), .BPC(1)) dut0 (.clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]), .out_valid(ov[0]),
    .out_ready(ory[0]), .out_code(oc0), .out_err(oe[0]));
  nbcac_encoder_seq #(.DATA_W(22), .CODE_W(31), .BPC(3)) dut1 (.clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]), .out_valid(ov[1]),
    .out_ready(ory[1]), .out_code(oc1), .out_err(oe[1]));
  nbcac_encoder_seq #(.DATA_W(22), .CODE_W(31), .BPC(29)) dut2 (.clk(clk), .rst(rst),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]), .out_valid(ov[2]),
    .out_ready(ory[2]), .out_code(oc2), .out_err(oe[2]));
  nbcac_encoder_seq #(.DATA_W(4), .CODE_W(5), .BPC(2)) dut3 (.clk(clk), .rst(rst),
    .in_valid(iv[3]), .in_ready(ir[3]), .in_data(id[3][3:0]), .out_valid(ov[3]),
    .out_ready(ory[3]), .out_code(oc3), .out_err(oe[3]));
  nbcac_encoder_seq #(.DATA_W(4), .CODE_W(4), .BPC(1)) dut4 (.clk(clk), .rst(rst),
    .in_valid(iv[4]), .in_ready(ir[4]), .in_data(id[4][3:0]), .out_valid(ov[4]),
    .out_ready(ory[4]), .out_code(oc4), .out_err(oe[4]));

  // Returns {err, code}: weights built from the recurrence, then the greedy cascade run stage by stage.
  function automatic logic [31:0] model(input int cw, input longint v);
    longint s[33];
    longint r;
    logic [30:0] c;
    logic dk;
    s[cw] = 2;
    s[cw-1] = 2;
    for (int k = cw - 2; k >= 2; k--) s[k] = s[k+1] + s[k+2];
    s[1] = 1;
    c = '0;
    c[0] = v[0];
    r = v - (v & 1);
    for (int k = 2; k < cw; k++) begin
      dk = (r >= s[k] + s[k+1]) ? 1'b1 : (r < s[k]) ? 1'b0 : c[k-2];
      c[k-1] = dk;
      if (dk) r = r - s[k];
    end
    c[cw-1] = r != 0;
    return {(r != 0) && (r != s[cw]), c};
  endfunction

  function automatic logic [31:0] dut_out(input int n);
    logic [30:0] c;
    c = n == 0 ? oc0 : n == 1 ? oc1 : n == 2 ? oc2 : n == 3 ? {26'b0, oc3} : {27'b0, oc4};
    return {oe[n], c};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic xfer(input int n, input logic [21:0] v, input int hold, output logic [31:0] res);
    int t;
    ory[n] = (hold == 0);
    @(negedge clk);
    id[n] = v;
    iv[n] = 1'b1;
    t = 0;
    while (!ir[n] && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    iv[n] = 1'b0;
    t = 0;
    while (!ov[n] && t < 100) begin @(negedge clk); t++; end
    chk($sformatf("out_valid_timeout%0d", n), ov[n], 1);
    res = dut_out(n);
    repeat (hold) @(negedge clk);
    ory[n] = 1'b1;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int n = 0; n < 5; n++) begin
      if (rst) q[n].delete();
      else begin
        if (iv[n] && ir[n]) begin
          q[n].push_back(model(cwv[n], longint'(id[n])));
          acc[n] = cyc;
        end
        if (ov[n] && ory[n] && q[n].size() > 0) void'(q[n].pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int n = 0; n < 5; n++) begin
        chk($sformatf("in_ready%0d", n), ir[n], q[n].size() == 0);
        if (q[n].size() == 0) chk($sformatf("valid_idle%0d", n), ov[n], 0);
        else if (ov[n]) begin
          chk($sformatf("codeword%0d", n), dut_out(n), q[n][0]);
          if (chk_acc[n] != acc[n]) begin
            chk($sformatf("latency%0d", n), cyc - acc[n], (cwv[n] - 2 + bpv[n] - 1) / bpv[n]);
            chk_acc[n] = acc[n];
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 5; n++) begin
      iv[n] = 1'b0;
      ory[n] = 1'b1;
      id[n] = '0;
    end
    chk("pin_v2", model(31, 2), 32'h4000_0000);
    chk("pin_v4", model(31, 4), 32'h6000_0000);
    chk("pin_c5_15", model(5, 15), 32'h0000_001F);
    chk("pin_c5_8", model(5, 8), 32'h0000_001C);
    chk("pin_c4_15", model(4, 15), 32'h8000_000F);
    repeat (2) @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("reset_ready%0d", n), ir[n], 1);
      chk($sformatf("reset_valid%0d", n), ov[n], 0);
      chk($sformatf("reset_out%0d", n), dut_out(n), 0);
    end
    rst = 1'b0;
    xfer(0, 0, 0, got); chk("v0", got, 32'h0000_0000);
    xfer(0, 1, 0, got); chk("v1", got, 32'h0000_0001);
    xfer(0, 2, 0, got); chk("v2", got, 32'h4000_0000);
    xfer(0, 3, 0, got); chk("v3", got, 32'h4000_0001);
    xfer(0, 4, 0, got); chk("v4", got, 32'h6000_0000);
    // Backpressure with a second word already waiting at the input.
    ory[0] = 1'b0;
    @(negedge clk);
    id[0] = 5;
    iv[0] = 1'b1;
    @(negedge clk);
    id[0] = 6;
    for (int t = 0; t < 100 && !ov[0]; t++) @(negedge clk);
    chk("bp_valid", ov[0], 1);
    chk("bp_code", dut_out(0), 32'h6000_0001);
    repeat (7) begin
      @(negedge clk);
      chk("bp_hold_valid", ov[0], 1);
      chk("bp_hold_code", dut_out(0), 32'h6000_0001);
      chk("bp_busy", ir[0], 0);
    end
    ory[0] = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", ir[0], 1);
    @(negedge clk);
    iv[0] = 1'b0;
    for (int t = 0; t < 100 && !ov[0]; t++) @(negedge clk);
    chk("bp_second_code", dut_out(0), 32'h3000_0000);
    @(negedge clk);
    // Reset in the middle of a word.
    id[0] = 4;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", ir[0], 1);
    chk("midrst_valid", ov[0], 0);
    chk("midrst_code", dut_out(0), 0);
    rst = 1'b0;
    xfer(0, 3, 0, got); chk("after_rst_v3", got, 32'h4000_0001);
    xfer(1, 4, 0, got); chk("bpc3_v4", got, 32'h6000_0000);
    xfer(2, 4, 0, got); chk("bpc29_v4", got, 32'h6000_0000);
    xfer(3, 15, 0, got); chk("c5_v15", got, 32'h0000_001F);
    xfer(3, 8, 0, got); chk("c5_v8", got, 32'h0000_001C);
    xfer(4, 15, 0, got); chk("c4_v15", got, 32'h8000_000F);
    for (int v = 0; v < 16; v++) begin
      xfer(3, 22'(v), 0, got);
      xfer(4, 22'(v), v % 3, got);
    end
    for (int i = 0; i < 200; i++) begin
      xfer(1, 22'($urandom_range(0, 22'h3F_FFFF)), i % 4, got);
      xfer(2, 22'($urandom_range(0, 22'h3F_FFFF)), 0, got);
    end
    for (int i = 0; i < 30; i++) xfer(0, 22'($urandom_range(0, 22'h3F_FFFF)), 0, got);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
